ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
//  Producer side of the key_in/key_en interface consumed by the VGA game controller.
//  - Receives PS/2 keyboard frames on ps2_clk/ps2_dat and strips the F0 (break) and E0 (extended) prefixes.
//  - Emits a one-cycle key_en strobe with the make code on key_in.
//  - Runs entirely in the iVGA_CLK domain, 25 MHz.
// PARAMETERS
//  FILTER_LEN   8      consecutive equal samples needed to accept a level change on ps2_clk
//  TIMEOUT_CYC  25000  idle cycles between PS/2 clock falls before a partial frame is dropped (1 ms)
// PORTS
//  iVGA_CLK   in   1  system clock; all logic posedge
//  iRST_n     in   1  asynchronous, active-low reset
//  ps2_clk    in   1  raw PS/2 clock from connector (async)
//  ps2_dat    in   1  raw PS/2 data from connector (async)
//  key_in     out  8  last accepted make code; held until next make
//  key_en     out  1  one-cycle strobe: key_in valid and new
//  key_ext    out  1  key_in was E0-prefixed; valid with key_en
//  frame_err  out  1  one-cycle strobe on parity/start/stop/timeout error
// BEHAVIOUR
//  Reset values: key_in=8'h00, key_en=0, key_ext=0, frame_err=0, FSM=IDLE, prefix flags=0.
//  Input conditioning:
//   - ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
//   - ps2_clk is then glitch-filtered: the filtered level changes only after FILTER_LEN identical samples.
//   - The bit strobe is the falling edge of the filtered clock.
//   - Data is sampled from synchronised ps2_dat on that strobe.
//  Frame = start(0), D0..D7 LSB first, odd parity, stop(1); 11 strobes per frame.
//  FSM states and transitions:
//   - IDLE -> DATA on a strobe with dat=0. A strobe with dat=1 is ignored.
//   - DATA: shift 8 bits in, 3-bit counter -> PARITY.
//   - PARITY: latch bit -> STOP.
//   - STOP: on the strobe, check ^{data,parity}==1 and stop==1, then return to IDLE.
//     Good frame: pulse byte_valid internally. Bad frame: pulse frame_err, discard byte, clear both prefix flags.
//  Timeout:
//   - 15-bit counter, cleared on every strobe and held at 0 in IDLE.
//   - Reaching TIMEOUT_CYC outside IDLE: FSM -> IDLE, frame_err pulse, byte discarded.
//  Byte decode on byte_valid:
//   - F0: set brk, no output.
//   - E0: set ext, no output.
//   - Any other byte with brk=1: no output; clear brk and ext.
//   - Any other byte with brk=0: next cycle key_in=byte, key_ext=ext, key_en=1; clear ext.
//   - Typematic repeats (repeated makes) are emitted each time.
//  Latency: key_en rises on the cycle after the cycle the stop-bit strobe is detected; width is exactly 1 cycle.
//  Simultaneous events: a strobe in the same cycle as timeout expiry is treated as the strobe (counter clears, no error).
//  Reset mid-frame: everything returns to reset values immediately; partial byte is lost.
//  Consumer contract: key_en is a pulse, not a level; the consumer must not rely on key_in changing to see repeats.
// STRUCTURE
//  Shared package ps2_pkg:
//   - localparams SC_BREAK=8'hF0, SC_EXT=8'hE0
//   - arrow codes SC_LEFT=8'h6B, SC_RIGHT=8'h74, SC_DOWN=8'h72, SC_UP=8'h75
//   - FSM state enum {IDLE,DATA,PARITY,STOP}
//  Sub-module ps2_frame_rx: synchronisers, filter, FSM, timeout.
//   - Outputs byte_valid, byte[7:0], frame_err.
//  Top level: prefix flags and output registers only.
// TESTING
//  1 E0,74 sent at 10 kHz PS/2 clock -> one key_en pulse, key_in=8'h74, key_ext=1, frame_err=0.
//  2 E0,F0,74 (release) -> no key_en; flags cleared; a following 1C -> key_in=8'h1C, key_ext=0.
//  3 Byte 6B with parity bit inverted -> frame_err 1 cycle, no key_en, key_in keeps previous value.
//  4 Start bit plus 4 data bits, then clock idle 2 ms -> frame_err at TIMEOUT_CYC; next full frame 72 decodes.
//  5 3-cycle low glitch on ps2_clk mid-frame -> ignored; byte 75 decoded correctly.
//  6 iRST_n low during bit 5 of frame -> all outputs 0; next frame decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receive path.
//   - Scan-code constants for the break/extended prefixes and the arrow keys
//   - Receive FSM state encoding
//   - Odd-parity check helper used on every completed frame
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Turns the raw asynchronous PS/2 clock/data pair into validated bytes.
//   iVGA_CLK      in   system clock (posedge)
//   iRST_n        in   asynchronous active-low reset
//   ps2_clk_i     in   raw PS/2 clock
//   ps2_dat_i     in   raw PS/2 data
//   byte_valid_o  out  one-cycle strobe: data_byte_o holds a good frame
//   data_byte_o   out  received byte (LSB first on the wire)
//   frame_err_o   out  one-cycle strobe: parity/stop error or timeout
// byte_valid_o and frame_err_o are decoded from registered state in the
// cycle the stop-bit strobe is seen; the top level registers them.
// ---------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       byte_valid_o,
    output logic [7:0] data_byte_o,
    output logic       frame_err_o
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          clk_m_q, clk_sync_q;
    logic          dat_m_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic [14:0]   to_cnt_q;

    logic          strobe_s;
    logic          expire_s;
    logic          stop_seen_s;
    logic          frame_ok_s;

    // Two-flop synchronisers; both lines idle high.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_m_q    <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_m_q    <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_m_q    <= ps2_clk_i;
            clk_sync_q <= clk_m_q;
            dat_m_q    <= ps2_dat_i;
            dat_sync_q <= dat_m_q;
        end
    end

    // Glitch filter next state: count consecutive samples that disagree with
    // the filtered level and flip only on the FILTER_LEN-th one.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = flt_cnt_q;
        if (clk_sync_q == filt_q) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d    = clk_sync_q;
            flt_cnt_d = '0;
        end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
        end
    end

    // Glitch filter state registers.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    // Bit strobe is the cycle in which the filtered clock falls.
    assign strobe_s = filt_q & ~filt_d;

    // A strobe in the expiry cycle wins, so expiry requires no strobe.
    assign expire_s = (state_q != IDLE) && !strobe_s &&
                      (to_cnt_q == 15'(TIMEOUT_CYC - 1));

    assign stop_seen_s = strobe_s && (state_q == STOP);
    assign frame_ok_s  = odd_parity_ok(shreg_q, par_q) && dat_sync_q;

    // Frame FSM with bit counter, shift register and inter-strobe timeout.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
            par_q     <= 1'b0;
            to_cnt_q  <= 15'd0;
        end else if (strobe_s) begin
            to_cnt_q <= 15'd0;
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= 3'd0;
                    if (!dat_sync_q) begin
                        state_q <= DATA;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    shreg_q   <= {dat_sync_q, shreg_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= PARITY;
                    end else begin
                        state_q <= DATA;
                    end
                end
                PARITY: begin
                    par_q   <= dat_sync_q;
                    state_q <= STOP;
                end
                STOP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end else if (state_q == IDLE) begin
            to_cnt_q <= 15'd0;
        end else if (expire_s) begin
            state_q  <= IDLE;
            to_cnt_q <= 15'd0;
        end else begin
            to_cnt_q <= to_cnt_q + 15'd1;
        end
    end

    assign byte_valid_o = stop_seen_s & frame_ok_s;
    assign frame_err_o  = (stop_seen_s & ~frame_ok_s) | expire_s;
    assign data_byte_o  = shreg_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// PS/2 keyboard front end feeding the VGA game controller.
//   iVGA_CLK   in   25 MHz system clock
//   iRST_n     in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock
//   ps2_dat    in   raw PS/2 data
//   key_in     out  last make code, held until the next make
//   key_en     out  one-cycle strobe: key_in is new
//   key_ext    out  key_in carried an E0 prefix (valid with key_en)
//   frame_err  out  one-cycle strobe on a bad or timed-out frame
// Break (F0) sequences are swallowed; only makes, including typematic
// repeats, produce key_en.
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] key_in,
    output logic       key_en,
    output logic       key_ext,
    output logic       frame_err
);

    logic       byte_valid_s;
    logic [7:0] rx_byte_s;
    logic       rx_err_s;

    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic [7:0] key_in_q, key_in_d;
    logic       key_en_q, key_en_d;
    logic       key_ext_q, key_ext_d;
    logic       frame_err_q;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .iVGA_CLK     (iVGA_CLK),
        .iRST_n       (iRST_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_dat_i    (ps2_dat),
        .byte_valid_o (byte_valid_s),
        .data_byte_o  (rx_byte_s),
        .frame_err_o  (rx_err_s)
    );

    // Prefix tracking and make-code selection for each received byte.
    always_comb begin
        brk_d     = brk_q;
        ext_d     = ext_q;
        key_in_d  = key_in_q;
        key_en_d  = 1'b0;
        key_ext_d = key_ext_q;
        if (rx_err_s) begin
            // A damaged frame may have been a prefix; forget any pending ones.
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (byte_valid_s) begin
            if (rx_byte_s == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (rx_byte_s == SC_EXT) begin
                ext_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                key_in_d  = rx_byte_s;
                key_ext_d = ext_q;
                key_en_d  = 1'b1;
                ext_d     = 1'b0;
            end
        end else begin
            brk_d = brk_q;
        end
    end

    // Prefix flags and output registers.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            key_in_q    <= 8'h00;
            key_en_q    <= 1'b0;
            key_ext_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            key_in_q    <= key_in_d;
            key_en_q    <= key_en_d;
            key_ext_q   <= key_ext_d;
            frame_err_q <= rx_err_s;
        end
    end

    assign key_in    = key_in_q;
    assign key_en    = key_en_q;
    assign key_ext   = key_ext_q;
    assign frame_err = frame_err_q;

endmodule
